mult_matrix_unskew: RTL and testbench
=====================================

MULT_MATRIX_UNSKEW -- requirements
Module: mult_matrix_unskew

Interface
REQ-001: The module SHALL have parameter data_size, default 4, giving the bit width of one matrix element.
REQ-002: The module SHALL have parameter size, default 3, giving the number of lanes (matrix dimension); legal range is 1..16.
REQ-003: The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004: The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005: The module SHALL have port input_stream, input, data_size*size bits: the skewed lane vector; lane i occupies bits [(size-i)*data_size-1 -: data_size], so lane 0 is the MSB slice.
REQ-006: The module SHALL have port in_valid, input, 1 bit: qualifies lane 0 of input_stream in the current cycle as the first element of a new row.
REQ-007: The module SHALL have port output_stream, output, data_size*size bits: the de-skewed row, using the same lane bit mapping as input_stream.
REQ-008: The module SHALL have port out_valid, output, 1 bit: high when output_stream holds a complete aligned row.
REQ-009: The module SHALL have port out_last, output, 1 bit: high with out_valid on the last row (row size-1) of a matrix.
REQ-010: The module SHALL have port out_row, output, max(1,$clog2(size)) bits: index of the row currently presented on output_stream.

Function
REQ-011: The block SHALL perform the inverse of the mult_matrix_prep skew: for a row whose lane-0 element arrives at cycle t, lane k's element of that row SHALL arrive at cycle t+k.
REQ-012: Each lane i SHALL pass through a delay line of exactly size-1-i registers, giving lane 0 size-1 stages and lane size-1 none.
REQ-013: The lane delay lines SHALL be followed by one output register covering all lanes, loaded every cycle.
REQ-014: Latency SHALL be exactly size cycles: in_valid sampled at edge t gives out_valid=1 and the aligned row on output_stream after edge t+size.
REQ-015: A valid pipe of size flops SHALL carry in_valid, and its last stage SHALL drive out_valid.
REQ-016: output_stream SHALL be undefined-by-spec when out_valid=0; it SHALL still follow the register pipeline and never be X after reset.
REQ-017: out_row SHALL increment by 1 on each cycle with out_valid=1, wrapping from size-1 to 0, and SHALL hold otherwise.
REQ-018: out_last SHALL equal out_valid AND (out_row == size-1).
REQ-019: Rows SHALL be accepted back-to-back, one per cycle, with no bubbles or throughput loss.
REQ-020: Gaps in in_valid of any length SHALL be allowed; out_row SHALL NOT reset on a gap, and matrix framing SHALL be purely by row count.
REQ-021: Trailing skewed beats arriving after in_valid drops SHALL still be captured correctly; the block SHALL NOT depend on in_valid for lanes 1..size-1.
REQ-022: For size=1 there are no delay stages; latency SHALL be 1, and out_last SHALL equal out_valid on every valid row.

Reset
REQ-023: When rst_n=0, all delay registers, the output register, the valid pipe and out_row SHALL clear to 0 immediately (asynchronously), giving output_stream=0, out_valid=0, out_last=0 and out_row=0.
REQ-024: Reset asserted mid-matrix SHALL discard all in-flight rows; no out_valid SHALL appear from beats sampled before rst_n rose.
REQ-025: After rst_n deasserts, the first rising edge SHALL sample inputs normally.

Verification (data_size=4, size=3)
REQ-026: Basic: in_valid=1,1,1,0,0 with input_stream=0x100,0x420,0x753,0x086,0x009 on cycles 0..4 -> out_valid=1 on cycles 3,4,5 with output_stream=0x123,0x456,0x789, out_row=0,1,2, and out_last=1 only on cycle 5.
REQ-027: Back-to-back: two matrices streamed with no gap -> six consecutive out_valid cycles, out_row 0,1,2,0,1,2, and out_last on the 3rd and 6th.
REQ-028: Gap: the same matrix with in_valid low for 2 cycles between rows 1 and 2 (skew preserved per row) -> rows emitted intact at their latency-3 positions, and out_row continues 0,1,2.
REQ-029: Reset mid-operation: rst_n pulled low on cycle 1 of the basic stimulus, then the basic stimulus restarted -> outputs 0 during reset, no spurious out_valid, then the restarted matrix appears with correct data and out_row starting at 0.
REQ-030: Wrap/idle: out_row=2 followed by 10 idle cycles -> out_row holds at 0 after the wrap, and out_valid stays 0.
REQ-031: The bench SHALL also run the basic scenario with size=1, input 0x5 and in_valid=1 -> output 0x5 one cycle later with out_last=1.

Source files
------------

// File: rtl/mult_matrix_unskew.sv
// Undoes the per-lane skew of a systolic row stream: lane i is delayed
// size-1-i cycles so every lane of a row lines up in one output register.
module mult_matrix_unskew #(
    parameter int data_size = 4,
    parameter int size      = 3,
    localparam int row_w    = (size > 1) ? $clog2(size) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [data_size*size-1:0] input_stream,
    input  logic                      in_valid,
    output logic [data_size*size-1:0] output_stream,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [row_w-1:0]          out_row
);

    logic [data_size-1:0]      lane_out [size];
    logic [data_size*size-1:0] out_q;
    logic [size-1:0]           vpipe;
    logic [row_w-1:0]          row_q;

    genvar i;
    for (i = 0; i < size; i++) begin : g_lane
        localparam int depth = size - 1 - i;
        logic [data_size-1:0] lane_in;

        assign lane_in = input_stream[(size-i)*data_size-1 -: data_size];

        if (depth == 0) begin : g_pass
            assign lane_out[i] = lane_in;
        end else begin : g_dly
            logic [data_size-1:0] pipe [depth];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < depth; j++) pipe[j] <= '0;
                end else begin
                    pipe[0] <= lane_in;
                    for (int j = 1; j < depth; j++) pipe[j] <= pipe[j-1];
                end
            end

            assign lane_out[i] = pipe[depth-1];
        end
    end

    // Output register and valid pipe are both free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            vpipe <= '0;
        end else begin
            for (int k = 0; k < size; k++) begin
                out_q[(size-k)*data_size-1 -: data_size] <= lane_out[k];
            end
            vpipe[0] <= in_valid;
            for (int k = 1; k < size; k++) vpipe[k] <= vpipe[k-1];
        end
    end

    // Row index tracks the row being presented; advances only on valid rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (vpipe[size-1]) begin
            if (row_q == row_w'(size - 1)) row_q <= '0;
            else                           row_q <= row_q + row_w'(1);
        end
    end

    assign output_stream = out_q;
    assign out_valid     = vpipe[size-1];
    assign out_row       = row_q;
    assign out_last      = vpipe[size-1] && (row_q == row_w'(size - 1));

endmodule

// File: tb/tb_mult_matrix_unskew.sv
// Scoreboard bench for mult_matrix_unskew: size=3 instance plus a size=1
// instance, directed rows with hand-written expected outputs.
module tb_mult_matrix_unskew;

    typedef struct {
        logic [11:0] data;
        logic [1:0]  row;
        logic        last;
        int          cyc;
    } exp3_t;

    typedef struct {
        logic [3:0] data;
        logic       last;
        int         cyc;
    } exp1_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] input_stream = '0;
    logic        in_valid = 1'b0;
    logic [11:0] output_stream;
    logic        out_valid;
    logic        out_last;
    logic [1:0]  out_row;

    logic [3:0]  in1_stream = '0;
    logic        in1_valid = 1'b0;
    logic [3:0]  out1_stream;
    logic        out1_valid;
    logic        out1_last;
    logic [0:0]  out1_row;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    exp3_t q3 [$];
    exp1_t q1 [$];

    mult_matrix_unskew #(.data_size(4), .size(3)) u3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_stream  (input_stream),
        .in_valid      (in_valid),
        .output_stream (output_stream),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_row       (out_row)
    );

    mult_matrix_unskew #(.data_size(4), .size(1)) u1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_stream  (in1_stream),
        .in_valid      (in1_valid),
        .output_stream (out1_stream),
        .out_valid     (out1_valid),
        .out_last      (out1_last),
        .out_row       (out1_row)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor for the size=3 instance.
    always @(negedge clk) begin
        if (out_valid) begin
            if (q3.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid3: got row 0x%0h expected none (cycle %0d)",
                         output_stream, cyc);
            end else begin
                exp3_t e;
                e = q3.pop_front();
                chk("latency3", cyc, e.cyc);
                chk("data3", {20'd0, output_stream}, {20'd0, e.data});
                chk("row3", {30'd0, out_row}, {30'd0, e.row});
                chk("last3", {31'd0, out_last}, {31'd0, e.last});
            end
        end else if (out_last) begin
            chk("last_without_valid3", {31'd0, out_last}, 32'd0);
        end
    end

    // Monitor for the size=1 instance.
    always @(negedge clk) begin
        if (out1_valid) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid1: got 0x%0h expected none (cycle %0d)",
                         out1_stream, cyc);
            end else begin
                exp1_t e;
                e = q1.pop_front();
                chk("latency1", cyc, e.cyc);
                chk("data1", {28'd0, out1_stream}, {28'd0, e.data});
                chk("last1", {31'd0, out1_last}, {31'd0, e.last});
                chk("row1", {31'd0, out1_row}, 32'd0);
            end
        end
    end

    task automatic step(input logic v, input logic [11:0] d);
        in_valid     = v;
        input_stream = d;
        @(posedge clk);
        #1;
    endtask

    // Skews the given rows onto the lanes per the valid pattern and, if
    // push is set, queues the expected aligned rows three cycles later.
    task automatic play(input logic [11:0] rows[$], input bit vld[$],
                        input logic [1:0] idx[$], input bit lst[$],
                        input bit push);
        logic [11:0] crow [$];
        int          r;
        int          start;
        int          n;
        start = cyc;
        r = 0;
        for (int c = 0; c < vld.size(); c++) begin
            if (vld[c]) begin
                crow.push_back(rows[r]);
                if (push) begin
                    exp3_t e;
                    e.data = rows[r];
                    e.row  = idx[r];
                    e.last = lst[r];
                    e.cyc  = start + c + 3;
                    q3.push_back(e);
                end
                r++;
            end else begin
                crow.push_back(12'h000);
            end
        end
        n = vld.size() + 2;
        for (int c = 0; c < n; c++) begin
            logic [11:0] beat;
            logic [11:0] src;
            beat = '0;
            for (int k = 0; k < 3; k++) begin
                int s;
                s = c - k;
                if (s >= 0 && s < vld.size()) begin
                    src = crow[s];
                    beat[(2-k)*4 +: 4] = src[(2-k)*4 +: 4];
                end
            end
            step((c < vld.size()) ? vld[c] : 1'b0, beat);
        end
    endtask

    task automatic check_idle3(input string name);
        chk({name, "_data"}, {20'd0, output_stream}, 32'd0);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_last"}, {31'd0, out_last}, 32'd0);
        chk({name, "_row"}, {30'd0, out_row}, 32'd0);
    endtask

    initial begin
        logic [11:0] rows [$];
        bit          vld  [$];
        logic [1:0]  idx  [$];
        bit          lst  [$];

        #2;
        check_idle3("reset");
        chk("reset1_data", {28'd0, out1_stream}, 32'd0);
        chk("reset1_valid", {31'd0, out1_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic: the literal skewed beats 0x100,0x420,0x753,0x086,0x009.
        q3.push_back('{12'h123, 2'd0, 1'b0, cyc + 3});
        q3.push_back('{12'h456, 2'd1, 1'b0, cyc + 4});
        q3.push_back('{12'h789, 2'd2, 1'b1, cyc + 5});
        step(1'b1, 12'h100);
        step(1'b1, 12'h420);
        step(1'b1, 12'h753);
        step(1'b0, 12'h086);
        step(1'b0, 12'h009);
        repeat (4) step(1'b0, 12'h000);

        // Back-to-back matrices.
        rows = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h314};
        vld  = '{1, 1, 1, 1, 1, 1};
        idx  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        lst  = '{0, 0, 1, 0, 0, 1};
        play(rows, vld, idx, lst, 1'b1);
        repeat (4) step(1'b0, 12'h000);

        // Two-cycle gap between rows 1 and 2.
        rows = '{12'h9E1, 12'h2F7, 12'h5C0};
        vld  = '{1, 1, 0, 0, 1};
        idx  = '{2'd0, 2'd1, 2'd2};
        lst  = '{0, 0, 1};
        play(rows, vld, idx, lst, 1'b1);
        repeat (4) step(1'b0, 12'h000);

        // Idle after wrap: out_row back at 0, nothing valid.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_row", {30'd0, out_row}, 32'd0);
        end

        // Reset on cycle 1 of the basic stimulus; aborted rows must vanish.
        @(posedge clk);
        #1;
        step(1'b1, 12'h100);
        in_valid     = 1'b1;
        input_stream = 12'h420;
        rst_n        = 1'b0;
        #1;
        check_idle3("async_reset");
        step(1'b1, 12'h753);
        check_idle3("in_reset");
        in_valid     = 1'b0;
        input_stream = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rows = '{12'h123, 12'h456, 12'h789};
        vld  = '{1, 1, 1};
        idx  = '{2'd0, 2'd1, 2'd2};
        lst  = '{0, 0, 1};
        play(rows, vld, idx, lst, 1'b1);
        repeat (4) step(1'b0, 12'h000);

        // size=1: no delay, latency 1, every row is last.
        q1.push_back('{4'h5, 1'b1, cyc + 1});
        q1.push_back('{4'hA, 1'b1, cyc + 2});
        in1_valid  = 1'b1;
        in1_stream = 4'h5;
        @(posedge clk);
        #1;
        in1_stream = 4'hA;
        @(posedge clk);
        #1;
        in1_valid  = 1'b0;
        in1_stream = 4'h0;
        repeat (4) @(posedge clk);
        #1;

        chk("pending3", q3.size(), 32'd0);
        chk("pending1", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
